// File: rtl/rv_pkg.sv
// Shared definitions for the front end: fetch FSM states, stop causes, widths and
// the base opcodes the control unit decodes.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StWait  = 2'b01,
    StHold  = 2'b10,
    StHalt  = 2'b11
  } fetch_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if;
  import rv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_gen.sv
// Next-PC selection for an accepted instruction: sequential or branch target, plus
// a flag for a branch target that is not word aligned.
module pc_next_gen
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o
);

  always_comb begin
    misalign_o = branch_taken_i && (branch_target_i[1:0] != 2'b00);
    // Sequential increment wraps modulo 2^32 by construction.
    pc_next_o  = branch_taken_i ? branch_target_i : pc_i + 32'd4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word over the imem bus, holds it until the
// decoder accepts it, and stops on a misaligned branch target or an imem timeout.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  fetch_unit_if.master     imem,
  output logic [ILEN-1:0]  instr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  output logic             halted_o,
  output logic [1:0]       err_code_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            halted_q, halted_d;
  logic [1:0]      err_q, err_d;

  logic [XLEN-1:0] pc_next;
  logic            misalign;
  logic [7:0]      cnt_inc;

  pc_next_gen u_pc_next_gen (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pc_next_o       (pc_next),
    .misalign_o      (misalign)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    err_d    = err_q;
    unique case (state_q)
      // Counter is zero in FETCH, so the first miss makes it 1 and every
      // request cycle without an ack counts toward the timeout.
      StFetch, StWait: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_inc == 8'(TIMEOUT)) begin
          cnt_d    = cnt_inc;
          halted_d = 1'b1;
          err_d    = ERR_TIMEOUT;
          state_d  = StHalt;
        end else begin
          cnt_d   = cnt_inc;
          state_d = StWait;
        end
      end
      StHold: begin
        if (instr_ready_i) begin
          if (misalign) begin
            halted_d = 1'b1;
            err_d    = ERR_MISALIGN;
            state_d  = StHalt;
          end else begin
            pc_d    = pc_next;
            state_d = StFetch;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Request is suppressed during the reset cycle so an abandoned fetch never leaks.
  assign imem.imem_req  = !rst && ((state_q == StFetch) || (state_q == StWait));
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign pc_o           = pc_q;
  assign instr_valid_o  = (state_q == StHold);
  assign halted_o       = halted_q;
  assign err_code_o     = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a transaction-level PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr, pc;
  logic        valid, ready, taken, halted;
  logic [31:0] target;
  logic [1:0]  err;

  logic        rst_w = 1'b1;
  logic [31:0] instr_w, pc_w;
  logic        valid_w, ready_w, taken_w, halted_w;
  logic [31:0] target_w;
  logic [1:0]  err_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_pc;

  fetch_unit_if ifc ();
  fetch_unit_if ifc_w ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (ifc),
    .instr_o         (instr),
    .pc_o            (pc),
    .instr_valid_o   (valid),
    .instr_ready_i   (ready),
    .branch_taken_i  (taken),
    .branch_target_i (target),
    .halted_o        (halted),
    .err_code_o      (err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) dut_w (
    .clk             (clk),
    .rst             (rst_w),
    .imem            (ifc_w),
    .instr_o         (instr_w),
    .pc_o            (pc_w),
    .instr_valid_o   (valid_w),
    .instr_ready_i   (ready_w),
    .branch_taken_i  (taken_w),
    .branch_target_i (target_w),
    .halted_o        (halted_w),
    .err_code_o      (err_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reset for one cycle, check the cleared state and the restart address.
  task automatic do_reset();
    rst = 1'b1;
    ready = 1'b0; taken = 1'b0; ifc.imem_ack = 1'b0;
    #1;
    chk("rst_req_low", 32'(ifc.imem_req), 0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0;
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_req", 32'(ifc.imem_req), 1);
    chk("rst_addr", ifc.imem_addr, 0);
  endtask

  // One instruction: ack after `delay` wait cycles, hold for `stall` cycles, then accept.
  task automatic fetch_txn(input int delay, input logic [31:0] data, input int stall,
                           input bit br, input logic [31:0] tgt);
    logic [31:0] old_pc;
    old_pc = m_pc;
    ready = 1'b0; taken = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      ifc.imem_ack   = (i == delay);
      ifc.imem_rdata = (i == delay) ? data : $urandom;
      #1;
      chk("fetch_req", 32'(ifc.imem_req), 1);
      chk("fetch_addr", ifc.imem_addr, old_pc);
      chk("fetch_valid", 32'(valid), 0);
      @(negedge clk);
    end
    for (int s = 0; s <= stall; s++) begin
      // Stray acks and branch inputs while holding must be ignored.
      ifc.imem_ack   = 1'($urandom);
      ifc.imem_rdata = $urandom;
      if (s == stall) begin
        ready = 1'b1; taken = br; target = tgt;
      end else begin
        ready = 1'b0; taken = 1'($urandom); target = $urandom;
      end
      #1;
      chk("hold_valid", 32'(valid), 1);
      chk("hold_instr", instr, data);
      chk("hold_pc", pc, old_pc);
      chk("hold_req", 32'(ifc.imem_req), 0);
      @(negedge clk);
    end
    ready = 1'b0; taken = 1'b0; ifc.imem_ack = 1'b0;
    if (br && tgt[1:0] != 2'b00) begin
      #1;
      chk("mis_halted", 32'(halted), 1);
      chk("mis_err", 32'(err), 1);
      chk("mis_req", 32'(ifc.imem_req), 0);
      chk("mis_valid", 32'(valid), 0);
      chk("mis_pc", pc, old_pc);
    end else begin
      m_pc = br ? tgt : old_pc + 32'd4;
      #1;
      chk("next_req", 32'(ifc.imem_req), 1);
      chk("next_addr", ifc.imem_addr, m_pc);
      chk("next_valid", 32'(valid), 0);
      chk("next_halted", 32'(halted), 0);
    end
  endtask

  initial begin
    ready = 1'b0; taken = 1'b0; target = '0;
    ifc.imem_ack = 1'b0; ifc.imem_rdata = '0;
    ready_w = 1'b0; taken_w = 1'b0; target_w = '0;
    ifc_w.imem_ack = 1'b0; ifc_w.imem_rdata = '0;
    m_pc = '0;
    @(negedge clk);
    do_reset();

    // Back-to-back single-cycle fetches: 0, 4, 8, 12
    for (int k = 0; k < 4; k++) fetch_txn(0, 32'h0000_0033, 0, 1'b0, 32'h0);

    // Delayed ack at address 4
    do_reset();
    fetch_txn(0, 32'h0000_0013, 0, 1'b0, 32'h0);
    fetch_txn(3, 32'h00A0_0093, 0, 1'b0, 32'h0);

    // Five stall cycles, then taken branch to 0x40
    fetch_txn(1, 32'h0000_0063, 5, 1'b1, 32'h0000_0040);
    chk("br_addr_40", ifc.imem_addr, 32'h40);

    // Misaligned branch target halts; request stays low
    fetch_txn(0, 32'h0000_0063, 1, 1'b1, 32'h0000_0042);
    for (int k = 0; k < 3; k++) begin
      ifc.imem_ack = 1'b1;
      @(negedge clk);
      #1;
      chk("halt_req", 32'(ifc.imem_req), 0);
      chk("halt_err", 32'(err), 1);
      chk("halt_instr", instr, 32'h0000_0063);
    end
    do_reset();

    // No ack: timeout after 16 request cycles
    for (int c = 0; c < 16; c++) begin
      chk("to_req", 32'(ifc.imem_req), 1);
      chk("to_halted_early", 32'(halted), 0);
      @(negedge clk);
      #1;
      chk("to_valid", 32'(valid), 0);
    end
    chk("to_halted", 32'(halted), 1);
    chk("to_err", 32'(err), 2);
    chk("to_req_off", 32'(ifc.imem_req), 0);

    // Randomized traffic against the PC model
    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] tg;
      bit          b;
      tg = $urandom & 32'hFFFF_FFFC;
      b  = ($urandom_range(0, 3) == 0);
      fetch_txn(int'($urandom_range(0, 5)), $urandom, int'($urandom_range(0, 3)), b, tg);
    end

    // PC wrap from 0xFFFFFFFC and reset in the middle of a wait
    rst_w = 1'b0;
    #1;
    chk("w_addr0", ifc_w.imem_addr, 32'hFFFF_FFFC);
    chk("w_req0", 32'(ifc_w.imem_req), 1);
    ifc_w.imem_ack = 1'b1; ifc_w.imem_rdata = 32'h0000_0013;
    @(negedge clk);
    ifc_w.imem_ack = 1'b0;
    ready_w = 1'b1;
    #1;
    chk("w_valid", 32'(valid_w), 1);
    chk("w_pc", pc_w, 32'hFFFF_FFFC);
    @(negedge clk);
    ready_w = 1'b0;
    #1;
    chk("w_wrap_addr", ifc_w.imem_addr, 32'h0);
    chk("w_wrap_err", 32'(err_w), 0);
    chk("w_wrap_halted", 32'(halted_w), 0);
    @(negedge clk);
    @(negedge clk);
    rst_w = 1'b1;
    #1;
    chk("w_rst_req", 32'(ifc_w.imem_req), 0);
    @(negedge clk);
    rst_w = 1'b0;
    #1;
    chk("w_rst_pc", pc_w, 32'hFFFF_FFFC);
    chk("w_rst_valid", 32'(valid_w), 0);
    for (int c = 0; c < 3; c++) @(negedge clk);
    #1;
    chk("w_to_early", 32'(halted_w), 0);
    @(negedge clk);
    #1;
    chk("w_to_halted", 32'(halted_w), 1);
    chk("w_to_err", 32'(err_w), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
